// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting one shared bus to one of 2**N requesters, with registered outputs.
// Define ARB_TIMEOUT_EN to enable forced release of an owner after MAX_HOLD busy cycles.
module rr_bus_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**N-1:0]   req,
  input  logic              done,
  output logic [2**N-1:0]   grant,
  output logic [N-1:0]      grant_idx,
  output logic              grant_valid,
  output logic              timeout
);

  localparam int NREQ = 2**N;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

  logic [0:0]   state;
  logic [N-1:0] ptr;
  logic [N-1:0] pick_idx;
  logic         pick_found;
  logic         force_rel;
  logic         release_now;

  // Scan from ptr upward; N-bit addition wraps NREQ-1 back to 0 for free.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_idx   = ptr;
    pick_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[ptr + N'(i)]) begin
        pick_idx   = ptr + N'(i);
        pick_found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CW-1:0] hold_cnt;
  logic [NREQ-1:0] others;

  always_comb begin
    others    = req & ~grant;
    force_rel = (hold_cnt == CW'(MAX_HOLD - 1)) && (|others);
  end

  // Cleared on entry to BUSY, saturates at MAX_HOLD-1 while nobody else waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CW'(MAX_HOLD - 1)) begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  assign release_now = done || !req[grant_idx] || force_rel;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            grant       <= NREQ'(1) << pick_idx;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        default: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + N'(1);
            timeout     <= force_rel;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
